// File: rtl/uart_rx_if.sv
// uart_rx_if: pin/strobe bundle between the UART receiver and its neighbours.
//   tick         : 1-clk enable at NUM_TICKS x baud from the baud generator
//   rx_bit       : serial line, idle high, asynchronous to clk
//   data_out     : last correctly framed byte
//   rx_done_tick : 1-clk pulse, data_out just updated
//   frame_err    : 1-clk pulse, stop bit sampled low
// master drives tick/rx_bit and consumes the results; slave is the receiver.
interface uart_rx_if #(
  parameter int NBIT_DATA = 8
);
  logic                 tick;
  logic                 rx_bit;
  logic [NBIT_DATA-1:0] data_out;
  logic                 rx_done_tick;
  logic                 frame_err;

  modport master (output tick, rx_bit, input data_out, rx_done_tick, frame_err);
  modport slave  (input tick, rx_bit, output data_out, rx_done_tick, frame_err);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (start, NBIT_DATA data LSB-first, 1 stop).
//   clk   : system clock, all logic on posedge
//   reset : synchronous, active-high
//   bus   : uart_rx_if.slave (tick, rx_bit in; data_out, rx_done_tick, frame_err out)
// The line is resynchronised by two flops; the FSM only advances on tick and
// samples each bit at its centre by counting half a bit from the start edge,
// then a whole bit per data/stop bit.
module uart_rx #(
  parameter int NBIT_DATA     = 8,
  parameter int LEN_DATA      = 3,
  parameter int NUM_TICKS     = 16,
  parameter int LEN_NUM_TICKS = 4
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);

  localparam logic [LEN_NUM_TICKS-1:0] TICK_HALF = LEN_NUM_TICKS'(NUM_TICKS/2 - 1);
  localparam logic [LEN_NUM_TICKS-1:0] TICK_LAST = LEN_NUM_TICKS'(NUM_TICKS - 1);
  localparam logic [LEN_DATA-1:0]      BIT_LAST  = LEN_DATA'(NBIT_DATA - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                   state_q, state_d;
  logic [LEN_NUM_TICKS-1:0] tick_cnt_q, tick_cnt_d;
  logic [LEN_DATA-1:0]      num_bits_q, num_bits_d;
  logic [NBIT_DATA-1:0]     shift_q, shift_d;
  logic [NBIT_DATA-1:0]     dout_q, dout_d;
  logic                     done_q, done_d;
  logic                     ferr_q, ferr_d;
  logic [1:0]               sync_q, sync_d;
  logic                     rx_s;

  // Synchroniser resets to 1 so a reset never looks like a start edge.
  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      num_bits_q <= '0;
      shift_q    <= '0;
      dout_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      sync_q     <= 2'b11;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      num_bits_q <= num_bits_d;
      shift_q    <= shift_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      sync_q     <= sync_d;
    end
  end

  always_comb begin
    sync_d     = {sync_q[0], bus.rx_bit};
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    num_bits_d = num_bits_q;
    shift_d    = shift_q;
    dout_d     = dout_q;
    // Strobes default low so each lasts exactly one clk.
    done_d     = 1'b0;
    ferr_d     = 1'b0;
    if (bus.tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d    = START;
            tick_cnt_d = '0;
          end
        end
        START: begin
          // Mid start bit: still low means a real frame, high means a glitch.
          if (tick_cnt_q == TICK_HALF) begin
            tick_cnt_d = '0;
            num_bits_d = '0;
            state_d    = rx_s ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt_q == TICK_LAST) begin
            shift_d    = {rx_s, shift_q[NBIT_DATA-1:1]};
            tick_cnt_d = '0;
            if (num_bits_q == BIT_LAST) state_d = STOP;
            else                        num_bits_d = num_bits_q + 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        STOP: begin
          // Leave at mid-stop: the remaining half bit is the window for the
          // next start edge, so back-to-back frames need no idle gap.
          if (tick_cnt_q == TICK_LAST) begin
            state_d    = IDLE;
            tick_cnt_d = '0;
            num_bits_d = '0;
            if (rx_s) begin
              dout_d = shift_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d    = IDLE;
          tick_cnt_d = '0;
          num_bits_d = '0;
        end
      endcase
    end
  end

  assign bus.data_out     = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed table + hand sequences + randomized frames for uart_rx.
// The reference model works at frame level: every frame sent queues one
// expected outcome (good byte or framing error), and the monitor retires them.
module tb_uart_rx;

  logic clk;
  logic reset;
  uart_rx_if #(.NBIT_DATA(8)) u_if ();

  uart_rx dut (.clk(clk), .reset(reset), .bus(u_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Tick generator: one tick every tick_div clocks, updated on negedge.
  int tick_div = 1;
  int tdc      = 0;
  initial begin
    u_if.tick = 1'b0;
    forever begin
      @(negedge clk);
      tdc++;
      if (tdc >= tick_div) begin
        tdc = 0;
        u_if.tick = 1'b1;
      end else begin
        u_if.tick = 1'b0;
      end
    end
  end

  // Waits for n clk edges that carry a tick, then lands on a negedge.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!u_if.tick) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    u_if.rx_bit = b;
    wait_ticks(16);
  endtask

  task automatic idle_bits(input int n);
    repeat (n) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  // Monitor / scoreboard.
  typedef struct { logic err; logic [7:0] data; } exp_t;
  exp_t       sbq[$];
  logic       sb_en     = 1'b0;
  logic [7:0] last_good = 8'h00;
  int         done_cnt  = 0;
  int         err_cnt   = 0;
  logic       prev_done = 1'b0;
  logic       prev_err  = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (u_if.rx_done_tick || u_if.frame_err) begin
        chk("pulse_width", 32'((prev_done && u_if.rx_done_tick) || (prev_err && u_if.frame_err)), 0);
        chk("done_err_excl", 32'(u_if.rx_done_tick && u_if.frame_err), 0);
        if (u_if.rx_done_tick) done_cnt++;
        if (u_if.frame_err)    err_cnt++;
        if (sb_en) begin
          if (sbq.size() == 0) begin
            chk("sb_unexpected_event", 1, 0);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            if (u_if.rx_done_tick) begin
              chk("sb_kind_done", 32'(e.err), 0);
              chk("sb_data", 32'(u_if.data_out), 32'(e.data));
              last_good = e.data;
            end else begin
              chk("sb_kind_err", 32'(e.err), 1);
              chk("sb_data_hold", 32'(u_if.data_out), 32'(last_good));
            end
          end
        end
      end
      prev_done = u_if.rx_done_tick;
      prev_err  = u_if.frame_err;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    int         div;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t tv[6];

  initial begin
    logic       prev_bad;
    int         gap;
    logic [7:0] d;
    logic       stop;

    tv[0] = '{8'hA5, 1'b1, 2, 1, 1, 0, 8'hA5};
    tv[1] = '{8'h00, 1'b1, 1, 1, 1, 0, 8'h00};
    tv[2] = '{8'hFF, 1'b1, 0, 1, 1, 0, 8'hFF};  // back-to-back with 0x00
    tv[3] = '{8'h12, 1'b1, 0, 1, 1, 0, 8'h12};
    tv[4] = '{8'h55, 1'b0, 0, 1, 0, 1, 8'h12};  // bad stop, data holds
    tv[5] = '{8'hC3, 1'b1, 2, 3, 1, 0, 8'hC3};  // tick every 3 clk

    reset       = 1'b1;
    u_if.rx_bit = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_data_out", 32'(u_if.data_out), 0);
    chk("reset_done", 32'(u_if.rx_done_tick), 0);
    chk("reset_ferr", 32'(u_if.frame_err), 0);

    foreach (tv[i]) begin
      tick_div = tv[i].div;
      idle_bits(tv[i].gap);
      done_cnt = 0;
      err_cnt  = 0;
      send_frame(tv[i].data, tv[i].stop);
      chk($sformatf("tv%0d_done_cnt", i), 32'(done_cnt), 32'(tv[i].exp_done));
      chk($sformatf("tv%0d_err_cnt", i), 32'(err_cnt), 32'(tv[i].exp_err));
      chk($sformatf("tv%0d_data_out", i), 32'(u_if.data_out), 32'(tv[i].exp_dout));
    end
    tick_div = 1;

    // Glitch: 4 ticks low is rejected at mid start bit, then a good frame.
    idle_bits(2);
    done_cnt = 0;
    err_cnt  = 0;
    u_if.rx_bit = 1'b0;
    wait_ticks(4);
    u_if.rx_bit = 1'b1;
    wait_ticks(32);
    chk("glitch_no_done", 32'(done_cnt), 0);
    chk("glitch_no_err", 32'(err_cnt), 0);
    chk("glitch_data_hold", 32'(u_if.data_out), 32'h C3);
    send_frame(8'h3C, 1'b1);
    chk("after_glitch_done", 32'(done_cnt), 1);
    chk("after_glitch_data", 32'(u_if.data_out), 32'h3C);

    // Break: 400 ticks low; one error every 153 ticks after detection -> 2.
    idle_bits(2);
    done_cnt = 0;
    err_cnt  = 0;
    u_if.rx_bit = 1'b0;
    wait_ticks(400);
    chk("break_err_cnt", 32'(err_cnt), 2);
    chk("break_no_done", 32'(done_cnt), 0);
    chk("break_data_hold", 32'(u_if.data_out), 32'h3C);
    reset       = 1'b1;
    u_if.rx_bit = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("break_reset_data", 32'(u_if.data_out), 0);

    // Reset during data bit 4 of 0x81, preceded by a good 0x5A.
    idle_bits(2);
    send_frame(8'h5A, 1'b1);
    chk("pre_reset_data", 32'(u_if.data_out), 32'h5A);
    done_cnt = 0;
    err_cnt  = 0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h81 >> i));
    u_if.rx_bit = 1'b0;
    wait_ticks(8);
    reset       = 1'b1;
    u_if.rx_bit = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midframe_reset_data", 32'(u_if.data_out), 0);
    idle_bits(12);
    chk("midframe_no_done", 32'(done_cnt), 0);
    chk("midframe_no_err", 32'(err_cnt), 0);
    send_frame(8'h81, 1'b1);
    chk("post_reset_done", 32'(done_cnt), 1);
    chk("post_reset_data", 32'(u_if.data_out), 32'h81);

    // Randomized frames against the frame-level model.
    last_good = 8'h81;
    sb_en     = 1'b1;
    prev_bad  = 1'b0;
    for (int n = 0; n < 24; n++) begin
      // After a bad stop the line needs a high bit so the false start that
      // follows mid-stop is rejected cleanly.
      gap = prev_bad ? 2 : int'($urandom_range(0, 2));
      if (gap >= 2) tick_div = int'($urandom_range(1, 4));
      idle_bits(gap);
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      sbq.push_back('{!stop, d});
      send_frame(d, stop);
      prev_bad = !stop;
    end
    idle_bits(2);
    chk("sb_drain", 32'(sbq.size()), 0);
    sb_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
